fifo_frame_unpacker: RTL and testbench

Read-side consumer of the 140-bit async FIFO, running in the FIFO's `clk_out` domain. It pops one 140-bit frame at a time and splits it into a 4-bit channel ID, an 8-bit CRC field and a 128-bit payload. The payload is streamed to the downstream datapath as `BEAT_W`-bit beats under a valid/ready handshake. It also keeps a running count of delivered frames.

---
 rtl/frame_pkg.sv | 24 ++
 rtl/crc8_128.sv | 26 ++
 rtl/fifo_frame_unpacker.sv | 139 +++++++++++++
 tb/tb_fifo_frame_unpacker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Frame layout, FSM state encoding and CRC constant shared by the FIFO frame unpacker.
// The CHECK state exists only when CRC_CHECK_EN is defined.
package frame_pkg;

  localparam int unsigned DW        = 140;
  localparam int unsigned CH_W      = 4;
  localparam int unsigned CH_MSB    = 139;
  localparam int unsigned CRC_W     = 8;
  localparam int unsigned CRC_MSB   = 135;
  localparam int unsigned PAYLOAD_W = 128;

  localparam logic [CRC_W-1:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
`ifdef CRC_CHECK_EN
    CHECK,
`endif
    SEND
  } unpk_state_t;

endpackage

// File: rtl/crc8_128.sv
// Combinational CRC-8 (poly 0x07, init 0, no final XOR) over a 128-bit payload, MSB first.
// Only built when CRC_CHECK_EN is defined.
`ifdef CRC_CHECK_EN
module crc8_128
  import frame_pkg::*;
(
  input  logic [PAYLOAD_W-1:0] data,
  output logic [CRC_W-1:0]     crc_c
);

  logic [PAYLOAD_W-1:0] sh;
  logic [CRC_W-1:0]     acc;

  // Bit-serial LFSR unrolled across the whole payload.
  always_comb begin
    sh  = data;
    acc = '0;
    for (int unsigned i = 0; i < PAYLOAD_W; i++) begin
      acc = {acc[CRC_W-2:0], 1'b0} ^ ((acc[CRC_W-1] ^ sh[PAYLOAD_W-1]) ? CRC8_POLY : '0);
      sh  = sh << 1;
    end
    crc_c = acc;
  end

endmodule
`endif

// File: rtl/fifo_frame_unpacker.sv
// Pops 140-bit frames from the async FIFO read side and streams the payload as BEAT_W-bit beats.
// Define CRC_CHECK_EN to verify the crc8 field and silently drop mismatching frames.
module fifo_frame_unpacker
  import frame_pkg::*;
#(
  parameter int unsigned DW     = frame_pkg::DW,
  parameter int unsigned BEAT_W = 16
) (
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DW-1:0]     data_from_fifo,
  output logic              fifo_r_enable,
  output logic [BEAT_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  input  logic              data_ready,
  output logic [CH_W-1:0]   ch_id,
  output logic              crc_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned NBEAT = PAYLOAD_W / BEAT_W;
  localparam int unsigned KW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  unpk_state_t          state, state_d;
  logic [KW-1:0]        k, k_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CH_W-1:0]      ch_d;
  logic [15:0]          cnt_d;
  logic                 ren_d, valid_d, last_d, err_d;
  logic [BEAT_W-1:0]    out_d;

`ifdef CRC_CHECK_EN
  logic [CRC_W-1:0] crc_q, crc_d, crc_calc_c;

  crc8_128 u_crc (
    .data  (payload_q),
    .crc_c (crc_calc_c)
  );
`else
  logic unused_crc_field;
  assign unused_crc_field = ^data_from_fifo[CRC_MSB -: CRC_W];
`endif

  // Beat 0 is the most significant slice of the payload.
  function automatic logic [BEAT_W-1:0] beat_of(input logic [PAYLOAD_W-1:0] p,
                                                input logic [KW-1:0]        idx);
    return BEAT_W'(p >> ((NBEAT - 1 - 32'(idx)) * BEAT_W));
  endfunction

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state;
    k_d       = k;
    payload_d = payload_q;
    ch_d      = ch_id;
    cnt_d     = frame_cnt;
    err_d     = 1'b0;
`ifdef CRC_CHECK_EN
    crc_d     = crc_q;
`endif
    case (state)
      IDLE: if (!fifo_empty) state_d = REQ;
      REQ:  state_d = LOAD;
      LOAD: begin
        payload_d = data_from_fifo[PAYLOAD_W-1:0];
        ch_d      = data_from_fifo[CH_MSB -: CH_W];
        k_d       = '0;
`ifdef CRC_CHECK_EN
        crc_d     = data_from_fifo[CRC_MSB -: CRC_W];
        state_d   = CHECK;
`else
        state_d   = SEND;
`endif
      end
`ifdef CRC_CHECK_EN
      CHECK: begin
        if (crc_calc_c == crc_q) begin
          state_d = SEND;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      SEND: begin
        if (data_valid && data_ready) begin
          if (k == KW'(NBEAT - 1)) begin
            k_d     = '0;
            cnt_d   = frame_cnt + 16'd1;
            state_d = IDLE;
          end else begin
            k_d = k + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ren_d   = (state_d == REQ);
    valid_d = (state_d == SEND);
    last_d  = valid_d && (k_d == KW'(NBEAT - 1));
    out_d   = valid_d ? beat_of(payload_d, k_d) : '0;
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      payload_q     <= '0;
      ch_id         <= '0;
      frame_cnt     <= '0;
      fifo_r_enable <= 1'b0;
      data_valid    <= 1'b0;
      data_last     <= 1'b0;
      data_out      <= '0;
      crc_err       <= 1'b0;
`ifdef CRC_CHECK_EN
      crc_q         <= '0;
`endif
    end else begin
      state         <= state_d;
      k             <= k_d;
      payload_q     <= payload_d;
      ch_id         <= ch_d;
      frame_cnt     <= cnt_d;
      fifo_r_enable <= ren_d;
      data_valid    <= valid_d;
      data_last     <= last_d;
      data_out      <= out_d;
      crc_err       <= err_d;
`ifdef CRC_CHECK_EN
      crc_q         <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// Randomized self-checking bench for fifo_frame_unpacker against a frame-level scoreboard.
// Define CRC_CHECK_EN for both the DUT and this bench to exercise CRC drops.
module tb_fifo_frame_unpacker;

  localparam int unsigned DW     = 140;
  localparam int unsigned BEAT_W = 16;
  localparam int unsigned NBEAT  = 128 / BEAT_W;
`ifdef CRC_CHECK_EN
  localparam int LOAD_LAT = 3;
`else
  localparam int LOAD_LAT = 2;
`endif

  logic              clk_out = 1'b0;
  logic              rst_n;
  logic              fifo_empty;
  logic [DW-1:0]     data_from_fifo;
  logic              fifo_r_enable;
  logic [BEAT_W-1:0] data_out;
  logic              data_valid;
  logic              data_last;
  logic              data_ready;
  logic [3:0]        ch_id;
  logic              crc_err;
  logic [15:0]       frame_cnt;

  fifo_frame_unpacker #(.DW(DW), .BEAT_W(BEAT_W)) dut (
    .clk_out        (clk_out),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .data_from_fifo (data_from_fifo),
    .fifo_r_enable  (fifo_r_enable),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_last      (data_last),
    .data_ready     (data_ready),
    .ch_id          (ch_id),
    .crc_err        (crc_err),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk_out = ~clk_out;

  // Reference model state: FIFO contents, beats still owed, and spec-derived timing stamps.
  logic [DW-1:0]     fifo_q[$];
  logic [BEAT_W-1:0] exp_beat[$];
  logic [3:0]        exp_ch = '0;
  bit                active = 1'b0;
  bit                rst_prev = 1'b0;
  bit                empty_prev = 1'b1;
  int                cyc = 0;
  int                idle_since = -1;
  int                valid_from = 0;
  int                err_at = -100;
  int                exp_cnt = 0;
  int                n_checks = 0;
  int                n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
  endtask

  // CRC as the remainder of (payload * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [127:0] p);
    logic [135:0] r;
    r = {p, 8'h00};
    repeat (128) begin
      if (r[135]) r[135:127] = r[135:127] ^ 9'h107;
      r = r << 1;
    end
    return r[135:128];
  endfunction

  function automatic bit frame_ok(input logic [DW-1:0] f);
`ifdef CRC_CHECK_EN
    return f[135:128] == ref_crc(f[127:0]);
`else
    return (f[139:136] == f[139:136]);
`endif
  endfunction

  task automatic push(input logic [3:0] ch, input logic [7:0] crc, input logic [127:0] p);
    fifo_q.push_back({ch, crc, p});
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, drive inputs.
  task automatic step(input bit rst_now, input int ready_pct);
    bit            er, ev, rdy;
    logic [DW-1:0] f;
    logic [127:0]  tmp;
    @(negedge clk_out);
    cyc++;
    rdy = ($urandom_range(99) < ready_pct);
    if (!rst_prev) begin
      chk("reset_outputs_zero",
          64'({fifo_r_enable, data_valid, data_last, crc_err, ch_id, data_out, frame_cnt}), 64'd0);
    end else begin
      er = (idle_since >= 0) && (idle_since <= cyc - 1) && !empty_prev;
      ev = active && (cyc >= valid_from);
      chk("fifo_r_enable", 64'(fifo_r_enable), 64'(er));
      chk("data_valid", 64'(data_valid), 64'(ev));
      if (ev && data_valid && exp_beat.size() != 0) begin
        chk("data_out", 64'(data_out), 64'(exp_beat[0]));
        chk("data_last", 64'(data_last), 64'(exp_beat.size() == 1));
        chk("ch_id", 64'(ch_id), 64'(exp_ch));
      end
      chk("crc_err", 64'(crc_err), 64'(cyc == err_at));
      chk("frame_cnt", 64'(frame_cnt), 64'(16'(exp_cnt)));
      if (fifo_r_enable && fifo_q.size() != 0) begin
        f = fifo_q.pop_front();
        data_from_fifo = f;
        idle_since = -1;
        if (frame_ok(f)) begin
          active = 1'b1;
          exp_ch = f[139:136];
          valid_from = cyc + LOAD_LAT;
          exp_beat.delete();
          for (int j = 0; j < int'(NBEAT); j++) begin
            tmp = f[127:0] << (BEAT_W * j);
            exp_beat.push_back(tmp[127 -: BEAT_W]);
          end
        end else begin
          err_at = cyc + 3;
          idle_since = cyc + 3;
        end
      end
      if (ev && rdy && !rst_now && exp_beat.size() != 0) begin
        void'(exp_beat.pop_front());
        if (exp_beat.size() == 0) begin
          active = 1'b0;
          exp_cnt = (exp_cnt + 1) % 65536;
          idle_since = cyc + 1;
        end
      end
    end
    if (rst_now) begin
      active = 1'b0;
      exp_beat.delete();
      exp_cnt = 0;
      err_at = -100;
      idle_since = cyc + 1;
    end
    rst_n = !rst_now;
    data_ready = rdy;
    fifo_empty = (fifo_q.size() == 0);
    empty_prev = fifo_empty;
    rst_prev = rst_n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((active || fifo_q.size() != 0 || idle_since < 0 || idle_since > cyc) && n < 3000) begin
      step(1'b0, 100);
      n++;
    end
    chk("drain_done", 64'(active || fifo_q.size() != 0), 64'd0);
  endtask

  localparam logic [127:0] P1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  initial begin
    logic [127:0] p;
    logic [7:0]   c;
    rst_n = 1'b0;
    data_ready = 1'b0;
    data_from_fifo = '0;
    push(4'h3, ref_crc(P1), P1);
    fifo_empty = 1'b0;
    empty_prev = 1'b0;

    // Reset held with a frame waiting, then a single frame.
    repeat (4) step(1'b1, 100);
    drain();
    chk("cnt_single", 64'(frame_cnt), 64'd1);

    // Backpressure on beat 4455 with another frame queued behind it.
    push(4'h3, ref_crc(P1), P1);
    p = {$urandom, $urandom, $urandom, $urandom};
    push(4'hA, ref_crc(p), p);
    for (int i = 0; i < 40; i++) begin
      if (active && exp_beat.size() != 0 && exp_beat[0] == 16'h4455) break;
      step(1'b0, 100);
    end
    repeat (5) step(1'b0, 0);
    drain();
    chk("cnt_backpressure", 64'(frame_cnt), 64'd3);

    // Back-to-back frames.
    for (int i = 0; i < 2; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      push(4'(i + 5), ref_crc(p), p);
    end
    drain();
    chk("cnt_back_to_back", 64'(frame_cnt), 64'd5);

    // Reset after the third beat is accepted; nothing stale may follow.
    push(4'h7, ref_crc(P1), P1);
    for (int i = 0; i < 40; i++) begin
      if (active && exp_beat.size() == NBEAT - 3) break;
      step(1'b0, 100);
    end
    step(1'b1, 100);
    repeat (6) step(1'b0, 100);
    chk("cnt_after_reset", 64'(frame_cnt), 64'd0);
    push(4'h9, ref_crc(P1), P1);
    drain();
    chk("cnt_after_reset_frame", 64'(frame_cnt), 64'd1);

`ifdef CRC_CHECK_EN
    push(4'h1, 8'h00, 128'd0);
    drain();
    chk("cnt_crc_good", 64'(frame_cnt), 64'd2);
    push(4'h2, 8'h5A, 128'd0);
    drain();
    chk("cnt_crc_bad", 64'(frame_cnt), 64'd2);
`endif

    // Random frames, random gaps and random backpressure.
    for (int i = 0; i < 40; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      c = ref_crc(p);
`ifdef CRC_CHECK_EN
      if ($urandom_range(3) == 0) c = c ^ 8'($urandom_range(255, 1));
`else
      c = 8'($urandom);
`endif
      push(4'($urandom), c, p);
      repeat ($urandom_range(12)) step(1'b0, 70);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
